// File: rtl/fetch_pkg.sv
// Shared fetch types: IF/ID payload struct, bubble constant and default reset PC.
// FETCH_MISALIGN_TRAP_EN adds the misaligned flag to the IF/ID payload.
`include "common/defines.svh"

package fetch_pkg;

  localparam int unsigned DATA_W  = `DATA_WIDTH;
  localparam int unsigned INSTR_W = `INSTR_WIDTH;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = `NOP_INSTRUCTION;
  localparam logic [DATA_W-1:0]  DEFAULT_RESET_PC = DATA_W'(32'h0000_0000);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               misaligned;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, pc_plus4: '0,
                                      instr: NOP_INSTR, misaligned: 1'b0};
`else
  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, pc_plus4: '0,
                                      instr: NOP_INSTR};
`endif

endpackage

// File: rtl/common/defines.svh
// Core-wide width and encoding macros shared by the fetch stage and its consumers.
`ifndef COMMON_DEFINES_SVH
`define COMMON_DEFINES_SVH

`define DATA_WIDTH      32
`define INSTR_WIDTH     32
`define NOP_INSTRUCTION 32'h0000_0013

`endif

// File: rtl/if_id_register.sv
// Pipeline register with stall/flush; flush beats stall, reset loads a bubble.
// Payload layout depends on FETCH_MISALIGN_TRAP_EN through fetch_pkg::if_id_t.
module if_id_register
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, instruction memory address and IF/ID capture.
// FETCH_MISALIGN_TRAP_EN keeps unaligned redirect targets and flags them in IF/ID.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_f,
  input  logic               flush_d,
  input  logic               redirect_valid,
  input  logic [DATA_W-1:0]  redirect_target,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_id_valid,
  output logic [DATA_W-1:0]  if_id_pc,
  output logic [DATA_W-1:0]  if_id_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic               if_id_misaligned,
`endif
  output logic [INSTR_W-1:0] if_id_instr
);

  logic [DATA_W-1:0] pc_f;
  logic [DATA_W-1:0] pc_plus4_c;
  logic [DATA_W-1:0] pc_target_c;
  logic [DATA_W-1:0] pc_next_c;
  if_id_t            if_id_d_c;
  if_id_t            if_id_q;

  assign pc_plus4_c = pc_f + DATA_W'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign pc_target_c = redirect_target;
`else
  assign pc_target_c = redirect_target & ~DATA_W'(3);
`endif

  // Redirect outranks stall; otherwise advance by one word (wraps naturally).
  always_comb begin
    pc_next_c = pc_plus4_c;
    if (redirect_valid) begin
      pc_next_c = pc_target_c;
    end else if (stall_f) begin
      pc_next_c = pc_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next_c;
    end
  end

  always_comb begin
    if_id_d_c          = IF_ID_BUBBLE;
    if_id_d_c.valid    = 1'b1;
    if_id_d_c.pc       = pc_f;
    if_id_d_c.pc_plus4 = pc_plus4_c;
    if_id_d_c.instr    = imem_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (pc_f[1:0] != 2'b00) begin
      if_id_d_c.instr      = NOP_INSTR;
      if_id_d_c.misaligned = 1'b1;
    end
`endif
  end

  // A redirect discards the wrong-path word currently at pc_f.
  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .stall (stall_f),
    .flush (flush_d | redirect_valid),
    .d     (if_id_d_c),
    .q     (if_id_q)
  );

  assign imem_addr      = pc_f;
  assign if_id_valid    = if_id_q.valid;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr    = if_id_q.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_id_misaligned = if_id_q.misaligned;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan steps plus random traffic.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_instruction_fetch;
  import fetch_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               stall_f;
  logic               flush_d;
  logic               redirect_valid;
  logic [DATA_W-1:0]  redirect_target;
  logic [DATA_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_id_valid;
  logic [DATA_W-1:0]  if_id_pc;
  logic [DATA_W-1:0]  if_id_pc_plus4;
  logic [INSTR_W-1:0] if_id_instr;
  logic               mis_obs;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic               if_id_misaligned;
  assign mis_obs = if_id_misaligned;
`else
  assign mis_obs = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic [31:0] m_instr;
  logic        m_mis;

  always #5 clk = ~clk;

  // Program image: addi x1..x4 at 0..12, a hashed pattern everywhere else.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h0010_0093;
      32'h4:   mem = 32'h0020_0113;
      32'h8:   mem = 32'h0030_8193;
      32'hC:   mem = 32'h0011_0213;
      default: mem = (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_instr = mem(imem_addr);

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
    .if_id_misaligned(if_id_misaligned),
`endif
    .if_id_instr     (if_id_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_ipc = '0; m_ipc4 = '0;
    m_instr = 32'h0000_0013; m_mis = 1'b0;
  endtask

  // Apply one rising edge's worth of the fetch rules to the model.
  task automatic model_edge();
    logic [31:0] old_pc;
    logic [31:0] tgt;
    old_pc = m_pc;
    tgt = TRAP_EN ? redirect_target : (redirect_target & ~32'h3);
    if (redirect_valid)  m_pc = tgt;
    else if (!stall_f)   m_pc = old_pc + 32'h4;
    if (redirect_valid || flush_d) begin
      m_valid = 1'b0; m_ipc = '0; m_ipc4 = '0; m_instr = 32'h0000_0013; m_mis = 1'b0;
    end else if (!stall_f) begin
      m_valid = 1'b1; m_ipc = old_pc; m_ipc4 = old_pc + 32'h4;
      if (TRAP_EN && old_pc[1:0] != 2'b00) begin
        m_instr = 32'h0000_0013; m_mis = 1'b1;
      end else begin
        m_instr = mem(old_pc); m_mis = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".valid"},     32'(if_id_valid), 32'(m_valid));
    chk({tag, ".pc"},        if_id_pc, m_ipc);
    chk({tag, ".pc_plus4"},  if_id_pc_plus4, m_ipc4);
    chk({tag, ".instr"},     if_id_instr, m_instr);
    chk({tag, ".mis"},       32'(mis_obs), 32'(m_mis));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] tgt);
    stall_f = st; flush_d = fl; redirect_valid = rv; redirect_target = tgt;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Sequential fetch from RESET_PC
    step("edge1");
    chk("edge1.valid_const", 32'(if_id_valid), 32'h1);
    chk("edge1.pc_const",    if_id_pc, 32'h0);
    chk("edge1.pc4_const",   if_id_pc_plus4, 32'h4);
    chk("edge1.instr_const", if_id_instr, 32'h0010_0093);
    chk("edge1.addr_const",  imem_addr, 32'h4);
    step("edge2");
    chk("edge2.addr_const",  imem_addr, 32'h8);

    // Stall for three edges while pc_f = 8
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.addr_const",  imem_addr, 32'h8);
      chk("stall.pc_const",    if_id_pc, 32'h4);
      chk("stall.instr_const", if_id_instr, 32'h0020_0113);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("release");
    chk("release.pc_const", if_id_pc, 32'h8);
    step("edge4");
    chk("edge4.instr_const", if_id_instr, 32'h0011_0213);
    chk("edge4.addr_const",  imem_addr, 32'h10);

    // Redirect to 0x40
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    step("redir");
    chk("redir.bubble_const", 32'(if_id_valid), 32'h0);
    chk("redir.addr_const",   imem_addr, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("redir_next");
    chk("redir_next.pc_const", if_id_pc, 32'h40);

    // Redirect, stall and flush together
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    step("all3");
    chk("all3.addr_const",  imem_addr, 32'h20);
    chk("all3.instr_const", if_id_instr, 32'h0000_0013);

    // Address wrap-around
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap_redir");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("wrap");
    chk("wrap.addr_const", imem_addr, 32'h0);
    chk("wrap.pc4_const",  if_id_pc_plus4, 32'h0);

    // Misaligned redirect target
    drive(1'b0, 1'b0, 1'b1, 32'h22);
    step("mis_redir");
    chk("mis_redir.addr_const", imem_addr, TRAP_EN ? 32'h22 : 32'h20);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("mis_next");
    chk("mis_next.valid_const", 32'(if_id_valid), 32'h1);
    chk("mis_next.mis_const",   32'(mis_obs), TRAP_EN ? 32'h1 : 32'h0);
    if (TRAP_EN) chk("mis_next.instr_const", if_id_instr, 32'h0000_0013);
    step("mis_next2");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0) ? ($urandom() | 32'hFFFF_FF00) : 32'($urandom_range(0, 255)));
      step("rand");
    end

    // Asynchronous reset pulse mid-stream
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("pre_rst");
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rst = 1'b0;
    step("post_rst1");
    chk("post_rst1.pc_const", if_id_pc, 32'h0);
    step("post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
